update_dispatch: RTL and testbench

UPDATE_DISPATCH -- requirements
Module: update_dispatch

---
 rtl/hft_pkg.sv | 35 +++
 rtl/update_fifo.sv | 54 +++++
 rtl/update_dispatch.sv | 124 ++++++++++++
 tb/tb_update_dispatch.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// Shared update types for the dispatch path. Vertex/weight widths normally come from
// Const.vh; the guarded defaults below apply only when that header has not been read.
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

package hft_pkg;

  localparam int VERTEX_W = `PRED_WIDTH + 1;
  localparam int WEIGHT_W = `WEIGHT_WIDTH + 1;

  typedef struct packed {
    logic [VERTEX_W-1:0] src;
    logic [VERTEX_W-1:0] dst;
    logic [WEIGHT_W-1:0] e;
  } update_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RETIRE
  } dispatch_state_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/update_fifo.sv
// Circular update queue with a registered occupancy count; full/empty come from the count.
module update_fifo
  import hft_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  update_t din,
  output update_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  update_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  // A push is judged against the pre-pop occupancy, so a write into a full queue is lost
  // even when the head leaves in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/update_dispatch.sv
// Feeds queued host edge updates one at a time to the graph container, with a RUN watchdog.
// Define DISPATCH_STATS_EN to build the saturating drop/done statistics counters.
module update_dispatch
  import hft_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [`PRED_WIDTH:0]   wr_src,
  input  logic [`PRED_WIDTH:0]   wr_dst,
  input  logic [`WEIGHT_WIDTH:0] wr_e,
  output logic                 full,
  output logic [`PRED_WIDTH:0]   u_src,
  output logic [`PRED_WIDTH:0]   u_dst,
  output logic [`WEIGHT_WIDTH:0] u_e,
  output logic                 container_reset,
  input  logic                 container_done,
  output logic                 upd_done,
  output logic                 upd_timeout,
  output logic                 busy,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          done_cnt
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  dispatch_state_t state;
  logic [WD_W-1:0] watchdog;
  update_t         wr_upd;
  update_t         head;
  update_t         cur;
  logic            fifo_empty;
  logic            pop;

  assign wr_upd = '{src: wr_src, dst: wr_dst, e: wr_e};
  assign pop    = (state == LOAD);

  update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_upd),
    .dout  (head),
    .full  (full),
    .empty (fifo_empty)
  );

  assign u_src = cur.src;
  assign u_dst = cur.dst;
  assign u_e   = cur.e;
  assign busy  = (state != IDLE) || !fifo_empty;

  // The retire pulses are raised on the RUN exit edge so they are high for the RETIRE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cur             <= '0;
      container_reset <= 1'b1;
      upd_done        <= 1'b0;
      upd_timeout     <= 1'b0;
      watchdog        <= '0;
    end else begin
      upd_done    <= 1'b0;
      upd_timeout <= 1'b0;
      case (state)
        IDLE: begin
          container_reset <= 1'b1;
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          cur             <= head;
          container_reset <= 1'b0;
          state           <= RUN;
        end
        RUN: begin
          if (container_done) begin
            container_reset <= 1'b1;
            upd_done        <= 1'b1;
            state           <= RETIRE;
          end else if (watchdog == WD_LAST) begin
            container_reset <= 1'b1;
            upd_timeout     <= 1'b1;
            state           <= RETIRE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        RETIRE: begin
          watchdog <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [15:0] drop_q;
  logic [15:0] done_q;

  // Counted on the same edges that drop a write or raise upd_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      done_q <= '0;
    end else begin
      if (wr_en && full)                   drop_q <= sat_inc(drop_q);
      if (state == RUN && container_done) done_q <= sat_inc(done_q);
    end
  end

  assign drop_cnt = drop_q;
  assign done_cnt = done_q;
`else
  assign drop_cnt = '0;
  assign done_cnt = '0;
`endif

endmodule

// File: tb/tb_update_dispatch.sv
// Self-checking bench for update_dispatch: table vectors, directed corner sequences and
// randomized traffic checked against a timestamp-based transaction model.
module tb_update_dispatch;
  import hft_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 32;
  localparam int VW      = `PRED_WIDTH + 1;
  localparam int EW      = `WEIGHT_WIDTH + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          container_done = 1'b0;
  logic [VW-1:0] wr_src = '0;
  logic [VW-1:0] wr_dst = '0;
  logic [EW-1:0] wr_e = '0;
  logic [VW-1:0] u_src;
  logic [VW-1:0] u_dst;
  logic [EW-1:0] u_e;
  logic          full;
  logic          container_reset;
  logic          upd_done;
  logic          upd_timeout;
  logic          busy;
  logic [15:0]   drop_cnt;
  logic [15:0]   done_cnt;

  int tests = 0;
  int fails = 0;

  update_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_en           (wr_en),
    .wr_src          (wr_src),
    .wr_dst          (wr_dst),
    .wr_e            (wr_e),
    .full            (full),
    .u_src           (u_src),
    .u_dst           (u_dst),
    .u_e             (u_e),
    .container_reset (container_reset),
    .container_done  (container_done),
    .upd_done        (upd_done),
    .upd_timeout     (upd_timeout),
    .busy            (busy),
    .drop_cnt        (drop_cnt),
    .done_cnt        (done_cnt)
  );

  always #5 clk = ~clk;

  // Transaction model: queued entries carry their acceptance edge; an entry is dispatched
  // two edges after acceptance or three edges after the previous retire, whichever is later.
  typedef struct {
    update_t upd;
    int      acc;
  } qent_t;

  qent_t   q[$];
  int      cyc = 0;
  int      run_start = 0;
  int      free_edge = 0;
  int      retire_edge = -10;
  bit      in_flight = 0;
  bit      m_done = 0;
  bit      m_timeout = 0;
  update_t m_u = '0;
  int      m_drops = 0;
  int      m_dones = 0;

  function automatic update_t mk(input int s, input int d, input int w);
    update_t r;
    r.src = VW'(s);
    r.dst = VW'(d);
    r.e   = EW'(w);
    return r;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    bit acc;
    cyc++;
    m_done    = 0;
    m_timeout = 0;
    if (reset) begin
      q.delete();
      in_flight   = 0;
      m_u         = '0;
      m_drops     = 0;
      m_dones     = 0;
      free_edge   = 0;
      retire_edge = -10;
      return;
    end
    acc = wr_en && (q.size() < DEPTH);
    if (wr_en && !acc) m_drops++;
    if (in_flight) begin
      if (container_done)                 m_done = 1;
      else if (cyc == run_start + TIMEOUT) m_timeout = 1;
      if (m_done || m_timeout) begin
        in_flight   = 0;
        free_edge   = cyc + 3;
        retire_edge = cyc;
        if (m_done) m_dones++;
      end
    end
    if (!in_flight && q.size() > 0 && cyc >= free_edge && cyc >= q[0].acc + 2) begin
      m_u       = q[0].upd;
      void'(q.pop_front());
      in_flight = 1;
      run_start = cyc;
    end
    if (acc) q.push_back('{upd: mk(int'(wr_src), int'(wr_dst), int'(wr_e)), acc: cyc});
  endtask

  task automatic check_output();
    int exp_drop;
    int exp_done;
`ifdef DISPATCH_STATS_EN
    exp_drop = sat16(m_drops);
    exp_done = sat16(m_dones);
`else
    exp_drop = 0;
    exp_done = 0;
`endif
    cmp("container_reset", 64'(container_reset), 64'(!in_flight));
    cmp("full", 64'(full), 64'(q.size() == DEPTH));
    cmp("busy", 64'(busy), 64'(in_flight || q.size() > 0 || retire_edge == cyc));
    cmp("upd_done", 64'(upd_done), 64'(m_done));
    cmp("upd_timeout", 64'(upd_timeout), 64'(m_timeout));
    cmp("u_src", 64'(u_src), 64'(m_u.src));
    cmp("u_dst", 64'(u_dst), 64'(m_u.dst));
    cmp("u_e", 64'(u_e), 64'(m_u.e));
    cmp("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    cmp("done_cnt", 64'(done_cnt), 64'(exp_done));
  endtask

  task automatic apply_stimulus(input bit r, input bit w, input update_t d, input bit dn);
    reset          = r;
    wr_en          = w;
    wr_src         = d.src;
    wr_dst         = d.dst;
    wr_e           = d.e;
    container_done = dn;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_output();
  endtask

  task automatic idle(input bit dn);
    apply_stimulus(1'b0, 1'b0, mk(0, 0, 0), dn);
  endtask

  task automatic reset_dut();
    apply_stimulus(1'b1, 1'b0, mk(0, 0, 0), 1'b0);
    apply_stimulus(1'b1, 1'b0, mk(0, 0, 0), 1'b0);
  endtask

  task automatic drain(input bit dn, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      idle(dn);
      n++;
    end
    cmp("drain_busy", 64'(busy), 64'(0));
  endtask

  typedef struct {
    bit      r;
    bit      w;
    update_t d;
    bit      dn;
    int      reps;
    bit      cr;
    bit      ud;
    bit      bz;
    update_t u;
  } vec_t;

  vec_t    tbl[8];
  update_t ord[3];
  int      exp_stat3;
  int      exp_stat1;
  int      seen;
  int      run_cyc;
  int      pulses;
  int      t0;
  int      to_at;
  bit      dn;
  bit      saw_done;

  initial begin
`ifdef DISPATCH_STATS_EN
    exp_stat3 = 3;
    exp_stat1 = 1;
`else
    exp_stat3 = 0;
    exp_stat1 = 0;
`endif

    // Single update: reset, write 3/5/100, done 20 RUN cycles later, back to idle.
    tbl[0] = '{r: 1, w: 0, d: mk(0, 0, 0),   dn: 0, reps: 2,  cr: 1, ud: 0, bz: 0, u: mk(0, 0, 0)};
    tbl[1] = '{r: 0, w: 1, d: mk(3, 5, 100), dn: 0, reps: 1,  cr: 1, ud: 0, bz: 1, u: mk(0, 0, 0)};
    tbl[2] = '{r: 0, w: 0, d: mk(0, 0, 0),   dn: 0, reps: 1,  cr: 1, ud: 0, bz: 1, u: mk(0, 0, 0)};
    tbl[3] = '{r: 0, w: 0, d: mk(0, 0, 0),   dn: 0, reps: 1,  cr: 0, ud: 0, bz: 1, u: mk(3, 5, 100)};
    tbl[4] = '{r: 0, w: 0, d: mk(0, 0, 0),   dn: 0, reps: 19, cr: 0, ud: 0, bz: 1, u: mk(3, 5, 100)};
    tbl[5] = '{r: 0, w: 0, d: mk(0, 0, 0),   dn: 1, reps: 1,  cr: 1, ud: 1, bz: 1, u: mk(3, 5, 100)};
    tbl[6] = '{r: 0, w: 0, d: mk(0, 0, 0),   dn: 0, reps: 1,  cr: 1, ud: 0, bz: 0, u: mk(3, 5, 100)};
    tbl[7] = '{r: 0, w: 0, d: mk(0, 0, 0),   dn: 0, reps: 3,  cr: 1, ud: 0, bz: 0, u: mk(3, 5, 100)};

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        apply_stimulus(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].dn);
        cmp($sformatf("vec%0d_cr", i), 64'(container_reset), 64'(tbl[i].cr));
        cmp($sformatf("vec%0d_done", i), 64'(upd_done), 64'(tbl[i].ud));
        cmp($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].bz));
        cmp($sformatf("vec%0d_u", i), 64'({u_src, u_dst, u_e}), 64'(tbl[i].u));
      end
    end

    // Fill: 9 writes accepted (head pops into LOAD), 10th dropped.
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, mk(i + 1, i + 2, i * 10), 1'b0);
      if (i == 8) cmp("fill_full_after9", 64'(full), 64'(1));
    end
    cmp("fill_full_after10", 64'(full), 64'(1));
    cmp("fill_drop_cnt", 64'(drop_cnt), 64'(exp_stat1));
    drain(1'b1, 200);

    // FIFO order with done returned after 5 RUN cycles each.
    reset_dut();
    ord[0] = mk(10, 11, 1000);
    ord[1] = mk(20, 21, 2000);
    ord[2] = mk(30, 31, 3000);
    seen = 0; run_cyc = 0; pulses = 0; dn = 0;
    for (int c = 0; c < 150 && pulses < 3; c++) begin
      apply_stimulus(1'b0, c < 3, (c < 3) ? ord[c] : mk(0, 0, 0), dn);
      dn = 0;
      if (upd_done) pulses++;
      if (!container_reset) begin
        if (run_cyc == 0 && seen < 3) begin
          cmp($sformatf("order_u%0d", seen), 64'({u_src, u_dst, u_e}), 64'(ord[seen]));
          seen++;
        end
        run_cyc++;
        if (run_cyc == 5) dn = 1;
      end else begin
        run_cyc = 0;
      end
    end
    cmp("order_dispatched", 64'(seen), 64'(3));
    cmp("order_pulses", 64'(pulses), 64'(3));
    cmp("order_done_cnt", 64'(done_cnt), 64'(exp_stat3));

    // Watchdog: no done, timeout pulse exactly TIMEOUT cycles after RUN entry.
    reset_dut();
    apply_stimulus(1'b0, 1'b1, mk(7, 9, 42), 1'b0);
    t0 = -1; to_at = -1; saw_done = 0;
    for (int c = 0; c < 3 * TIMEOUT && to_at < 0; c++) begin
      idle(1'b0);
      if (!container_reset && t0 < 0) t0 = c;
      if (upd_done) saw_done = 1;
      if (upd_timeout) to_at = c;
    end
    cmp("timeout_latency", 64'(to_at - t0), 64'(TIMEOUT));
    cmp("timeout_no_done", 64'(saw_done), 64'(0));
    idle(1'b0);
    cmp("timeout_pulse_width", 64'(upd_timeout), 64'(0));

    // Reset in RUN cycle 4 with two entries still queued.
    reset_dut();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, mk(i, i, i), 1'b0);
    cmp("rst_run_entered", 64'(container_reset), 64'(0));
    repeat (3) idle(1'b0);
    apply_stimulus(1'b1, 1'b0, mk(0, 0, 0), 1'b0);
    cmp("rst_cr", 64'(container_reset), 64'(1));
    cmp("rst_busy", 64'(busy), 64'(0));
    cmp("rst_done", 64'(upd_done), 64'(0));
    cmp("rst_timeout", 64'(upd_timeout), 64'(0));
    repeat (4) begin
      idle(1'b0);
      cmp("rst_stays_idle", 64'(container_reset), 64'(1));
    end

    // Done held high through IDLE and LOAD must not retire the update.
    reset_dut();
    apply_stimulus(1'b0, 1'b1, mk(1, 2, 3), 1'b1);
    idle(1'b1);
    idle(1'b1);
    cmp("early_done_cr", 64'(container_reset), 64'(0));
    cmp("early_done_pulse", 64'(upd_done), 64'(0));
    repeat (3) idle(1'b0);
    cmp("early_done_still_run", 64'(container_reset), 64'(0));
    idle(1'b1);
    cmp("early_done_retire", 64'(upd_done), 64'(1));
    drain(1'b0, 20);

    // Randomized traffic with occasional resets.
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      apply_stimulus($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                     mk(int'($urandom), int'($urandom), int'($urandom)),
                     $urandom_range(0, 7) == 0);
    end
    drain(1'b1, 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
